mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Memory-access stage directly downstream of the execute-stage ALU. Takes the ALU result Y as a load/store address or as a pass-through result. Runs byte/half/word loads and stores over a request/grant/response data-memory bus and hands a registered result to writeback through a valid/ready handshake. Flags misaligned accesses, illegal width codes and bus timeouts as exceptions instead of touching memory.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ or WAIT_R before a bus-error exception (1..65535)
RESET_PC_TAG, 0, reset value of wb_data (32 bits)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  stage can accept an op this cycle
ex_y  in  32  ALU result Y: address for mem ops, result otherwise
ex_store_data  in  32  rs2 value for stores
ex_funct3  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_mem_read  in  1  op is a load
ex_mem_write  in  1  op is a store (mem_read and mem_write both set is illegal)
ex_rd  in  5  destination register
ex_reg_write  in  1  op writes rd
mem_req  out  1  bus request
mem_we  out  1  store when 1
mem_addr  out  32  word-aligned address ({ex_y[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word
wb_valid  out  1  result valid to writeback
wb_ready  in  1  writeback accepts
wb_data  out  32  result / extended load data
wb_rd  out  5  destination register
wb_reg_write  out  1  write enable (forced 0 on exception)
wb_exc  out  1  exception flag
wb_exc_code  out  2  01 misaligned, 10 illegal width, 11 bus timeout, 00 none

Behaviour:
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wb_valid=0, wb_data=RESET_PC_TAG, wb_rd=0, wb_reg_write=0, wb_exc=0, wb_exc_code=00. State=IDLE, timeout counter=0.
- ex_ready = (state==IDLE) && (!wb_valid || wb_ready). Accept = ex_valid && ex_ready.
- States: IDLE, REQ, WAIT_R. Output register holds the wb_* fields; wb_valid clears on wb_ready unless it is reloaded in the same cycle.
- Non-memory op on accept: wb_* loaded next edge (latency 1), wb_data=ex_y. Stays in IDLE. Back-to-back throughput is 1 per cycle.
- Checks at accept, memory ops only, in priority order:
  - both mem_read and mem_write set, or funct3 illegal for the op (loads: 011/110/111; stores: anything other than 000/001/010) -> code 10.
  - H with ex_y[0]=1, or W with ex_y[1:0]!=0 -> code 01.
  - Either case: wb_valid next edge, wb_exc=1, wb_reg_write=0, wb_data=ex_y, no bus request.
- Legal memory op on accept: latch op, go to REQ. mem_req=1 from the next edge. mem_addr, mem_we, mem_wdata and mem_wstrb hold stable while mem_req=1.
- Store lanes (a=ex_y[1:0]):
  - SB: wstrb=0001<<a, wdata={4{byte}}
  - SH: wstrb=0011<<a, wdata={2{half}}
  - SW: wstrb=1111
  - Loads drive wstrb=0000.
- REQ + mem_gnt:
  - store: mem_req drops next edge; wb_valid next edge with wb_reg_write=0 and wb_data=address; go to IDLE.
  - load: mem_req drops; go to WAIT_R.
- WAIT_R + mem_rvalid: select the byte/half at offset a; sign-extend (B/H) or zero-extend (BU/HU); wb_valid next edge; go to IDLE. Load latency = 1 (REQ) + grant wait + response wait + 1.
- mem_rvalid in IDLE or REQ is ignored. mem_rvalid arriving in the same cycle as mem_gnt is not used; responses are only taken in WAIT_R.
- The timeout counter clears on entering REQ or WAIT_R and increments each cycle there. At TIMEOUT_CYCLES: drop mem_req, report wb_exc with code 11 and wb_reg_write=0, go to IDLE.
- Writeback stall: a result already in the output register holds stable while wb_ready=0. Completion of REQ/WAIT_R is only taken when (!wb_valid || wb_ready); otherwise the FSM stays in its state and mem_rvalid must be held by memory.
- rst mid-operation: next edge gives reset values and IDLE, aborting any transaction. A late mem_rvalid is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 width constants (F3_B/H/W/BU/HU)
  - state enum (IDLE, REQ, WAIT_R)
  - exception code constants (EXC_NONE, EXC_MISALIGN, EXC_ILLEGAL, EXC_BUSTO)
- Sub-module lsu_align: purely combinational.
  - Inputs: funct3, addr[1:0], store_data, rdata.
  - Outputs: wstrb, wdata, load result, misaligned, illegal.
- The FSM, handshakes and timeout counter stay in mem_stage_lsu.

Test Plan:
- ALU op ex_y=0x0000_1234, rd=5, reg_write=1, wb_ready=1 -> one cycle later wb_valid=1, wb_data=0x1234, wb_rd=5, no mem_req.
- SB ex_y=0x100, store_data=0xAABBCC_EF -> mem_req with mem_addr=0x100, wstrb=0001, wdata=0xEFEFEFEF. Gnt after 2 cycles -> wb_valid, wb_reg_write=0.
- LB ex_y=0x203, rdata=0x80FF_0000 -> wb_data=0xFFFF_FF80. Same access as LBU -> 0x0000_0080. LH at 0x202 -> 0xFFFF_80FF.
- LW ex_y=0x102 -> no mem_req, wb_exc=1, code 01, wb_reg_write=0. Load with funct3=011 -> code 10.
- TIMEOUT_CYCLES=4, gnt withheld -> mem_req drops after 4 cycles in REQ, wb_exc code 11. Assert rst in WAIT_R, then pulse mem_rvalid -> outputs at reset values, no wb_valid.
- wb_ready=0 with a result held -> ex_ready=0; wb_data stable over 3 cycles; a pending mem_rvalid held by memory is consumed once wb_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-access stage: width codes,
// FSM states and exception codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
  localparam logic [1:0] EXC_BUSTO    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    WAIT_R = 2'b10
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and
// width/alignment legality checks. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [31:0] shifted_s;

  // Lane steering, extension and legality checks.
  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = store_data_i;
    load_data_o  = 32'h0000_0000;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    shifted_s    = rdata_i >> {addr_i, 3'b000};

    if (is_store_i) begin
      illegal_o = !((funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W));
    end else begin
      illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    end

    // The low two bits select the access size for both signed and unsigned codes.
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{store_data_i[7:0]}};
        if (is_store_i) begin
          wstrb_o = 4'b0001 << addr_i;
        end else begin
          wstrb_o = 4'b0000;
        end
      end
      2'b01: begin
        misaligned_o = addr_i[0];
        wdata_o      = {2{store_data_i[15:0]}};
        if (is_store_i) begin
          wstrb_o = 4'b0011 << addr_i;
        end else begin
          wstrb_o = 4'b0000;
        end
      end
      2'b10: begin
        misaligned_o = (addr_i != 2'b00);
        wdata_o      = store_data_i;
        if (is_store_i) begin
          wstrb_o = 4'b1111;
        end else begin
          wstrb_o = 4'b0000;
        end
      end
      default: begin
        wstrb_o = 4'b0000;
      end
    endcase

    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   load_data_o = {24'h00_0000, shifted_s[7:0]};
      F3_H:    load_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   load_data_o = {16'h0000, shifted_s[15:0]};
      F3_W:    load_data_o = shifted_s;
      default: load_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: issues byte/half/word loads and stores on a
// req/gnt/rvalid bus and hands a registered result to writeback.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_PC_TAG   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_y_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_write_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_write_o,
  output logic        wb_exc_o,
  output logic [1:0]  wb_exc_code_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        op_load_q;
  logic [2:0]  op_f3_q;
  logic [31:0] op_addr_q;
  logic [4:0]  op_rd_q;
  logic        op_rw_q;

  logic        wb_free_s;
  logic        accept_s;
  logic        mem_op_s;
  logic [2:0]  sel_f3_s;
  logic [1:0]  sel_a_s;
  logic [3:0]  al_wstrb_s;
  logic [31:0] al_wdata_s;
  logic [31:0] al_load_s;
  logic        al_mis_s;
  logic        al_ill_s;

  assign wb_free_s  = !wb_valid_o || wb_ready_i;
  assign ex_ready_o = (state_q == IDLE) && wb_free_s;
  assign accept_s   = ex_valid_i && ex_ready_o;
  assign mem_op_s   = ex_mem_read_i || ex_mem_write_i;
  assign cnt_d      = cnt_q + 16'd1;

  // The aligner sees the incoming op while idle and the latched op afterwards.
  assign sel_f3_s = (state_q == IDLE) ? ex_funct3_i : op_f3_q;
  assign sel_a_s  = (state_q == IDLE) ? ex_y_i[1:0] : op_addr_q[1:0];

  lsu_align u_align (
    .funct3_i     (sel_f3_s),
    .addr_i       (sel_a_s),
    .is_store_i   (ex_mem_write_i),
    .store_data_i (ex_store_data_i),
    .rdata_i      (mem_rdata_i),
    .wstrb_o      (al_wstrb_s),
    .wdata_o      (al_wdata_s),
    .load_data_o  (al_load_s),
    .misaligned_o (al_mis_s),
    .illegal_o    (al_ill_s)
  );

  // FSM, bus outputs, timeout counter and writeback output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      op_load_q      <= 1'b0;
      op_f3_q        <= 3'b000;
      op_addr_q      <= 32'h0000_0000;
      op_rd_q        <= 5'd0;
      op_rw_q        <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= 32'h0000_0000;
      mem_wdata_o    <= 32'h0000_0000;
      mem_wstrb_o    <= 4'b0000;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= RESET_PC_TAG;
      wb_rd_o        <= 5'd0;
      wb_reg_write_o <= 1'b0;
      wb_exc_o       <= 1'b0;
      wb_exc_code_o  <= EXC_NONE;
    end else begin
      if (wb_valid_o && wb_ready_i) begin
        wb_valid_o <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            if (!mem_op_s) begin
              wb_valid_o     <= 1'b1;
              wb_data_o      <= ex_y_i;
              wb_rd_o        <= ex_rd_i;
              wb_reg_write_o <= ex_reg_write_i;
              wb_exc_o       <= 1'b0;
              wb_exc_code_o  <= EXC_NONE;
            end else if ((ex_mem_read_i && ex_mem_write_i) || al_ill_s || al_mis_s) begin
              wb_valid_o     <= 1'b1;
              wb_data_o      <= ex_y_i;
              wb_rd_o        <= ex_rd_i;
              wb_reg_write_o <= 1'b0;
              wb_exc_o       <= 1'b1;
              if ((ex_mem_read_i && ex_mem_write_i) || al_ill_s) begin
                wb_exc_code_o <= EXC_ILLEGAL;
              end else begin
                wb_exc_code_o <= EXC_MISALIGN;
              end
            end else begin
              state_q     <= REQ;
              cnt_q       <= 16'd0;
              op_load_q   <= ex_mem_read_i;
              op_f3_q     <= ex_funct3_i;
              op_addr_q   <= ex_y_i;
              op_rd_q     <= ex_rd_i;
              op_rw_q     <= ex_reg_write_i;
              mem_req_o   <= 1'b1;
              mem_we_o    <= ex_mem_write_i;
              mem_addr_o  <= {ex_y_i[31:2], 2'b00};
              mem_wdata_o <= al_wdata_s;
              mem_wstrb_o <= al_wstrb_s;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i && (op_load_q || wb_free_s)) begin
            mem_req_o <= 1'b0;
            if (op_load_q) begin
              state_q <= WAIT_R;
              cnt_q   <= 16'd0;
            end else begin
              state_q        <= IDLE;
              wb_valid_o     <= 1'b1;
              wb_data_o      <= op_addr_q;
              wb_rd_o        <= op_rd_q;
              wb_reg_write_o <= 1'b0;
              wb_exc_o       <= 1'b0;
              wb_exc_code_o  <= EXC_NONE;
            end
          end else if ((cnt_q >= TO_LAST) && wb_free_s) begin
            state_q        <= IDLE;
            mem_req_o      <= 1'b0;
            wb_valid_o     <= 1'b1;
            wb_data_o      <= op_addr_q;
            wb_rd_o        <= op_rd_q;
            wb_reg_write_o <= 1'b0;
            wb_exc_o       <= 1'b1;
            wb_exc_code_o  <= EXC_BUSTO;
          end else if (cnt_q < TO_LAST) begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i && wb_free_s) begin
            state_q        <= IDLE;
            wb_valid_o     <= 1'b1;
            wb_data_o      <= al_load_s;
            wb_rd_o        <= op_rd_q;
            wb_reg_write_o <= op_rw_q;
            wb_exc_o       <= 1'b0;
            wb_exc_code_o  <= EXC_NONE;
          end else if ((cnt_q >= TO_LAST) && wb_free_s) begin
            state_q        <= IDLE;
            wb_valid_o     <= 1'b1;
            wb_data_o      <= op_addr_q;
            wb_rd_o        <= op_rd_q;
            wb_reg_write_o <= 1'b0;
            wb_exc_o       <= 1'b1;
            wb_exc_code_o  <= EXC_BUSTO;
          end else if (cnt_q < TO_LAST) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
